// File: rtl/mavg_channel_sched.sv
// mavg_channel_sched
// Shares one moving-average engine among NCH sample channels. A round-robin
// arbiter grants one channel per cycle. Each channel keeps a WINDOW-deep
// history and a running sum, and one shared adder/shift unit updates them.
// Results leave on a single valid/ready stream tagged with the channel id,
// one cycle after the sample is accepted.
//
// Optional feature: define MAVG_SCHED_WARMUP_EN to suppress results until a
// channel has received WINDOW samples. When it is undefined, every accepted
// sample produces a result averaged against zero-initialised history.
//
// Ports:
//   system1000      clock
//   system1000_rst  synchronous active-high reset
//   in_valid[NCH]   per-channel sample valid
//   in_data         per-channel signed samples, channel k at [k*DW +: DW]
//   in_ready[NCH]   per-channel accept (one-hot or zero)
//   flush           synchronous clear of all channel history
//   out_valid       result valid
//   out_data        signed average
//   out_ch          channel id of the result
//   out_ready       downstream accept
//   busy            output pending or any input valid
module mavg_channel_sched #(
    parameter int NCH    = 4,
    parameter int WINDOW = 4,
    parameter int DW     = 8
) (
    input  logic                   system1000,
    input  logic                   system1000_rst,
    input  logic [NCH-1:0]         in_valid,
    input  logic [NCH*DW-1:0]      in_data,
    output logic [NCH-1:0]         in_ready,
    input  logic                   flush,
    output logic                   out_valid,
    output logic [DW-1:0]          out_data,
    output logic [$clog2(NCH)-1:0] out_ch,
    input  logic                   out_ready,
    output logic                   busy
);

    localparam int CW = $clog2(NCH);
    localparam int LW = $clog2(WINDOW);
    localparam int SW = DW + LW;
    localparam logic [CW-1:0] PTR_INIT = CW'(NCH - 1);

    logic signed [DW-1:0] hist [NCH][WINDOW];
    logic signed [SW-1:0] sum  [NCH];
    logic [CW-1:0]        ptr;

    logic                 grant_found;
    logic [CW-1:0]        grant_ch;
    logic                 can_accept;
    logic                 xfer;
    logic                 emit;
    logic signed [DW-1:0] sample;
    logic signed [DW-1:0] oldest;
    logic signed [SW-1:0] new_sum;
    logic [DW-1:0]        avg;

    // Search starts one past the last granted channel and wraps.
    always_comb begin
        int            idx;
        logic [CW-1:0] cand;
        grant_found = 1'b0;
        grant_ch    = '0;
        for (int i = 1; i <= NCH; i++) begin
            idx  = (int'(ptr) + i) % NCH;
            cand = CW'(idx);
            if (!grant_found && in_valid[cand]) begin
                grant_found = 1'b1;
                grant_ch    = cand;
            end
        end
    end

    assign can_accept = !out_valid || out_ready;

    always_comb begin
        in_ready = '0;
        if (grant_found && can_accept && !flush && !system1000_rst)
            in_ready[grant_ch] = 1'b1;
    end

    assign xfer = |in_ready;
    assign busy = out_valid || (|in_valid);

    assign sample  = in_data[grant_ch*DW +: DW];
    assign oldest  = hist[grant_ch][WINDOW-1];
    assign new_sum = sum[grant_ch] - {{LW{oldest[DW-1]}}, oldest}
                                   + {{LW{sample[DW-1]}}, sample};
    // Arithmetic shift floors toward minus infinity; the quotient always fits DW.
    assign avg     = DW'(new_sum >>> LW);

`ifdef MAVG_SCHED_WARMUP_EN
    logic [LW:0] fill [NCH];
    assign emit = fill[grant_ch] >= (LW+1)'(WINDOW - 1);
`else
    assign emit = 1'b1;
`endif

    always_ff @(posedge system1000) begin
        if (system1000_rst || flush) begin
            for (int k = 0; k < NCH; k++) begin
                for (int j = 0; j < WINDOW; j++)
                    hist[k][j] <= '0;
                sum[k] <= '0;
`ifdef MAVG_SCHED_WARMUP_EN
                fill[k] <= '0;
`endif
            end
            ptr       <= PTR_INIT;
            out_valid <= 1'b0;
            if (system1000_rst) begin
                out_data <= '0;
                out_ch   <= '0;
            end
        end else begin
            if (xfer) begin
                ptr <= grant_ch;
                for (int j = WINDOW - 1; j > 0; j--)
                    hist[grant_ch][j] <= hist[grant_ch][j-1];
                hist[grant_ch][0] <= sample;
                sum[grant_ch]     <= new_sum;
`ifdef MAVG_SCHED_WARMUP_EN
                if (fill[grant_ch] < (LW+1)'(WINDOW))
                    fill[grant_ch] <= fill[grant_ch] + 1'b1;
`endif
            end
            if (xfer && emit) begin
                out_valid <= 1'b1;
                out_data  <= avg;
                out_ch    <= grant_ch;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mavg_channel_sched.sv
module tb_mavg_channel_sched;

    localparam int NCH    = 4;
    localparam int WINDOW = 4;
    localparam int DW     = 8;
    localparam int CW     = 2;

    logic                system1000 = 1'b0;
    logic                system1000_rst;
    logic [NCH-1:0]      in_valid;
    logic [NCH*DW-1:0]   in_data;
    logic [NCH-1:0]      in_ready;
    logic                flush;
    logic                out_valid;
    logic [DW-1:0]       out_data;
    logic [CW-1:0]       out_ch;
    logic                out_ready;
    logic                busy;

    always #5 system1000 = ~system1000;

    mavg_channel_sched #(.NCH(NCH), .WINDOW(WINDOW), .DW(DW)) dut (
        .system1000     (system1000),
        .system1000_rst (system1000_rst),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_ch         (out_ch),
        .out_ready      (out_ready),
        .busy           (busy)
    );

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Reference model: full sample list per channel, average of the last
    // WINDOW samples (missing ones count as zero), floored division.
    int m_hist [NCH][$];
    int m_last;
    bit m_valid;
    int m_data;
    int m_ch;
    int m_fill [NCH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_avg(input int ch);
        int s = 0;
        int n = m_hist[ch].size();
        for (int i = 0; i < WINDOW; i++)
            if (n - 1 - i >= 0) s += m_hist[ch][n-1-i];
        if (s >= 0) return s / WINDOW;
        return -((-s + WINDOW - 1) / WINDOW);
    endfunction

    task automatic model_clear();
        for (int k = 0; k < NCH; k++) begin
            m_hist[k].delete();
            m_fill[k] = 0;
        end
        m_last  = NCH - 1;
        m_valid = 0;
    endtask

    function automatic logic [NCH*DW-1:0] pk(input int a, input int b, input int c, input int e);
        logic [NCH*DW-1:0] d;
        d[0*DW +: DW] = a[DW-1:0];
        d[1*DW +: DW] = b[DW-1:0];
        d[2*DW +: DW] = c[DW-1:0];
        d[3*DW +: DW] = e[DW-1:0];
        return d;
    endfunction

    // One clock cycle, entered and left at the falling edge.
    task automatic cyc(input bit r, input bit f, input logic [NCH-1:0] v,
                       input logic [NCH*DW-1:0] d, input bit ordy, input string tag);
        bit                   can;
        int                   g;
        int                   idx;
        bit                   emit;
        logic [NCH-1:0]       er;
        logic signed [DW-1:0] t;

        chk({tag, ":out_valid"}, 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            chk({tag, ":out_data"}, 32'(out_data), 32'(m_data & 255));
            chk({tag, ":out_ch"},   32'(out_ch),   32'(m_ch));
        end

        system1000_rst = r;
        flush          = f;
        in_valid       = v;
        in_data        = d;
        out_ready      = ordy;
        #1;

        can = !m_valid || ordy;
        g   = -1;
        for (int i = 1; i <= NCH; i++) begin
            idx = (m_last + i) % NCH;
            if (g < 0 && v[idx]) g = idx;
        end
        er = '0;
        if (!r && !f && can && g >= 0) er[g] = 1'b1;
        chk({tag, ":in_ready"}, 32'(in_ready), 32'(er));
        chk({tag, ":busy"},     32'(busy),     32'(m_valid || (|v)));

        if (r) begin
            model_clear();
            m_data = 0;
            m_ch   = 0;
        end else if (f) begin
            model_clear();
        end else if (er != '0) begin
            m_last = g;
            t = d[g*DW +: DW];
            m_hist[g].push_back(int'(t));
            if (m_hist[g].size() > WINDOW) void'(m_hist[g].pop_front());
`ifdef MAVG_SCHED_WARMUP_EN
            emit = (m_fill[g] >= WINDOW - 1);
            if (m_fill[g] < WINDOW) m_fill[g]++;
`else
            emit = 1;
`endif
            if (emit) begin
                m_valid = 1;
                m_data  = model_avg(g);
                m_ch    = g;
            end else if (ordy) begin
                m_valid = 0;
            end
        end else if (ordy) begin
            m_valid = 0;
        end

        @(posedge system1000);
        @(negedge system1000);
    endtask

    initial begin
        system1000_rst = 1'b1;
        flush          = 1'b0;
        in_valid       = '0;
        in_data        = '0;
        out_ready      = 1'b1;
        repeat (2) @(posedge system1000);
        @(negedge system1000);
        model_clear();
        m_data = 0;
        m_ch   = 0;
        chk("reset:out_valid", 32'(out_valid), 32'd0);
        chk("reset:out_data",  32'(out_data),  32'd0);
        chk("reset:out_ch",    32'(out_ch),    32'd0);

        // Channel 0 alone: 4,8,12,16
        cyc(0, 0, 4'b0001, pk(4, 0, 0, 0),  1, "tp1");
        cyc(0, 0, 4'b0001, pk(8, 0, 0, 0),  1, "tp1");
        cyc(0, 0, 4'b0001, pk(12, 0, 0, 0), 1, "tp1");
        cyc(0, 0, 4'b0001, pk(16, 0, 0, 0), 1, "tp1");
        cyc(0, 0, 4'b0000, pk(0, 0, 0, 0),  1, "tp1_idle");

        // Channel 1 at negative full scale, then -1 on fresh channel 2
        repeat (4) cyc(0, 0, 4'b0010, pk(0, -128, 0, 0), 1, "tp2");
        cyc(0, 0, 4'b0100, pk(0, 0, -1, 0), 1, "tp2_floor");
        cyc(0, 0, 4'b0000, pk(0, 0, 0, 0),  1, "tp2_idle");

        // All channels requesting: rotation
        repeat (6) cyc(0, 0, 4'b1111, pk(1, 2, 3, 4), 1, "tp3");
        cyc(0, 0, 4'b0000, pk(0, 0, 0, 0), 1, "tp3_idle");

        // Backpressure then release
        cyc(0, 0, 4'b0001, pk(20, 0, 0, 0), 1, "tp4_load");
        repeat (3) cyc(0, 0, 4'b0011, pk(24, 28, 0, 0), 0, "tp4_stall");
        cyc(0, 0, 4'b0011, pk(24, 28, 0, 0), 1, "tp4_release");
        cyc(0, 0, 4'b0000, pk(0, 0, 0, 0),   1, "tp4_idle");

        // Flush drops pending output and history
        cyc(0, 1, 4'b0000, pk(0, 0, 0, 0),  1, "tp5_clr");
        cyc(0, 0, 4'b0001, pk(40, 0, 0, 0), 1, "tp5");
        cyc(0, 0, 4'b0001, pk(40, 0, 0, 0), 1, "tp5");
        cyc(0, 1, 4'b0001, pk(8, 0, 0, 0),  0, "tp5_flush");
        cyc(0, 0, 4'b0001, pk(8, 0, 0, 0),  1, "tp5_after");
        cyc(0, 0, 4'b0000, pk(0, 0, 0, 0),  1, "tp5_idle");

        // Reset mid-stream
        cyc(0, 0, 4'b1110, pk(5, 6, 7, 8), 1, "tp6_pre");
        cyc(0, 0, 4'b1110, pk(5, 6, 7, 8), 0, "tp6_pre");
        cyc(1, 0, 4'b1111, pk(5, 6, 7, 8), 0, "tp6_rst");
        cyc(0, 0, 4'b1111, pk(5, 6, 7, 8), 1, "tp6_first");
        cyc(0, 0, 4'b0000, pk(0, 0, 0, 0), 1, "tp6_idle");
        cyc(1, 0, 4'b0000, pk(0, 0, 0, 0), 1, "tp6_rst2");
        cyc(0, 0, 4'b0001, pk(4, 0, 0, 0),  1, "tp6_seq");
        cyc(0, 0, 4'b0001, pk(8, 0, 0, 0),  1, "tp6_seq");
        cyc(0, 0, 4'b0001, pk(12, 0, 0, 0), 1, "tp6_seq");
        cyc(0, 0, 4'b0001, pk(16, 0, 0, 0), 1, "tp6_seq");
        cyc(0, 0, 4'b0000, pk(0, 0, 0, 0),  1, "tp6_idle");

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 39) == 0),
                NCH'($urandom), NCH*DW'($urandom), ($urandom_range(0, 3) != 0), "rnd");
        end
        cyc(0, 0, 4'b0000, pk(0, 0, 0, 0), 1, "final");
        chk("final:out_valid", 32'(out_valid), 32'(m_valid));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
